// File: rtl/decode_pkg.sv
// decode_pkg: shared types and constants for the decode stage.
//   opid_e     pre-decoded opcode IDs supplied by fetch
//   br_type_e  branch class handed to execute for resolution
//   ALU_*      ALU operation codes
//   MTR_*      writeback source select codes
//   ctrl_t     every datapath control bit carried in the ID/EX register
//   src_use_t  which register fields an opcode actually reads
package decode_pkg;

    typedef enum logic [3:0] {
        OP_ADDI = 4'd0,
        OP_ADDS = 4'd1,
        OP_BLT  = 4'd2,
        OP_B    = 4'd3,
        OP_BL   = 4'd4,
        OP_BR   = 4'd5,
        OP_CBZ  = 4'd6,
        OP_LDUR = 4'd7,
        OP_STUR = 4'd8,
        OP_SUBS = 4'd9
    } opid_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_B    = 3'd1,
        BR_BL   = 3'd2,
        BR_BR   = 3'd3,
        BR_BLT  = 3'd4,
        BR_CBZ  = 3'd5
    } br_type_e;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC4 = 2'b10;

    localparam logic [4:0] LINK_REG = 5'd30;
    localparam logic [4:0] ZERO_REG = 5'd31;

    typedef struct packed {
        logic       reg2loc;
        logic       alusrc;
        logic       regwrite;
        logic       memwrite;
        logic       uncondbr;
        logic       constsel;
        logic       flag_en;
        logic       reg3loc;
        logic       read_en;
        logic [1:0] memtoreg;
        logic [2:0] alu_op;
        br_type_e   br_type;
    } ctrl_t;

    typedef struct packed {
        logic rn;
        logic rm;
        logic rd;
    } src_use_t;

    localparam ctrl_t CTRL_NONE = '0;

endpackage

// File: rtl/op_ctrl_decode.sv
// op_ctrl_decode: combinational opcode decode.
//   opid     in   pre-decoded opcode ID
//   instr    in   raw instruction word
//   ctrl     out  datapath control bundle
//   illegal  out  opid is not a known opcode
//   rn/rm/rd out  register specifiers, 0 where the opcode does not use them
//   imm      out  selected immediate, sign-extended (ADDI zero-extended)
//   src_use  out  which of rn/rm/rd the opcode reads, for hazard checks
module op_ctrl_decode
    import decode_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [3:0]        opid,
    input  logic [31:0]       instr,
    output ctrl_t             ctrl,
    output logic              illegal,
    output logic [4:0]        rn,
    output logic [4:0]        rm,
    output logic [4:0]        rd,
    output logic [DATA_W-1:0] imm,
    output src_use_t          src_use
);

    logic [DATA_W-1:0] imm12;
    logic [DATA_W-1:0] imm9;
    logic [DATA_W-1:0] imm19;
    logic [DATA_W-1:0] imm26;
    logic              unused_bits;

    assign imm12 = DATA_W'(instr[21:10]);
    assign imm9  = {{(DATA_W-9){instr[20]}}, instr[20:12]};
    assign imm19 = {{(DATA_W-19){instr[23]}}, instr[23:5]};
    assign imm26 = {{(DATA_W-26){instr[25]}}, instr[25:0]};

    // The primary opcode bits are already folded into opid by fetch.
    assign unused_bits = ^instr[31:26];

    always_comb begin
        ctrl    = CTRL_NONE;
        illegal = 1'b0;
        rn      = '0;
        rm      = '0;
        rd      = '0;
        imm     = '0;
        src_use = '0;
        case (opid)
            OP_ADDI: begin
                ctrl.alusrc   = 1'b1;
                ctrl.constsel = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.alu_op   = ALU_ADD;
                rn            = instr[9:5];
                rd            = instr[4:0];
                imm           = imm12;
                src_use.rn    = 1'b1;
            end
            OP_ADDS, OP_SUBS: begin
                ctrl.regwrite = 1'b1;
                ctrl.flag_en  = 1'b1;
                ctrl.alu_op   = (opid == OP_SUBS) ? ALU_SUB : ALU_ADD;
                rn            = instr[9:5];
                rm            = instr[20:16];
                rd            = instr[4:0];
                src_use.rn    = 1'b1;
                src_use.rm    = 1'b1;
            end
            OP_BLT: begin
                ctrl.br_type = BR_BLT;
                imm          = imm19;
            end
            OP_B: begin
                ctrl.uncondbr = 1'b1;
                ctrl.br_type  = BR_B;
                imm           = imm26;
            end
            OP_BL: begin
                ctrl.uncondbr = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = MTR_PC4;
                ctrl.reg3loc  = 1'b1;
                ctrl.br_type  = BR_BL;
                rd            = LINK_REG;
                imm           = imm26;
            end
            OP_BR: begin
                ctrl.uncondbr = 1'b1;
                ctrl.br_type  = BR_BR;
                rn            = instr[9:5];
                src_use.rn    = 1'b1;
            end
            OP_CBZ: begin
                ctrl.reg2loc = 1'b1;
                ctrl.alu_op  = ALU_PASS;
                ctrl.br_type = BR_CBZ;
                rd           = instr[4:0];
                imm          = imm19;
                src_use.rd   = 1'b1;
            end
            OP_LDUR: begin
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = MTR_MEM;
                ctrl.read_en  = 1'b1;
                ctrl.alu_op   = ALU_ADD;
                rn            = instr[9:5];
                rd            = instr[4:0];
                imm           = imm9;
                src_use.rn    = 1'b1;
            end
            OP_STUR: begin
                ctrl.reg2loc  = 1'b1;
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.alu_op   = ALU_ADD;
                rn            = instr[9:5];
                rd            = instr[4:0];
                imm           = imm9;
                src_use.rn    = 1'b1;
                src_use.rd    = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: pipelined decode between fetch and execute.
//   clk, reset_n            clock, async active-low reset
//   in_valid/in_ready       fetch handshake; in_opid, in_instr, in_pc payload
//   flush                   squash the ID/EX register (taken branch in execute)
//   out_valid/out_ready     execute handshake for the registered bundle
//   out_pc, out_rn/rm/rd    registered PC and register specifiers
//   out_imm                 registered sign-extended immediate
//   out_* controls          registered datapath controls, out_illegal for unknown opids
// Interlocks: load-use (LDUR in ID/EX or in the LOAD_LAT shadow) and flag
// dependency (B.LT behind an ADDS/SUBS still in ID/EX or within FLAG_LAT).
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int LOAD_LAT = 1,
    parameter int FLAG_LAT = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_opid,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [4:0]        out_rn,
    output logic [4:0]        out_rm,
    output logic [4:0]        out_rd,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_reg2loc,
    output logic              out_alusrc,
    output logic              out_regwrite,
    output logic              out_memwrite,
    output logic              out_uncondbr,
    output logic              out_constsel,
    output logic              out_flag_en,
    output logic              out_reg3loc,
    output logic              out_read_en,
    output logic [1:0]        out_memtoreg,
    output logic [2:0]        out_alu_op,
    output logic [2:0]        out_br_type,
    output logic              out_illegal
);

    localparam int CNT_W = (FLAG_LAT < 1) ? 1 : $clog2(FLAG_LAT + 1);

    ctrl_t             dec_ctrl;
    logic              dec_illegal;
    logic [4:0]        dec_rn;
    logic [4:0]        dec_rm;
    logic [4:0]        dec_rd;
    logic [DATA_W-1:0] dec_imm;
    src_use_t          dec_use;

    ctrl_t             ctrl_reg;
    logic              shadow_valid [LOAD_LAT];
    logic [4:0]        shadow_rd    [LOAD_LAT];
    logic [CNT_W-1:0]  flag_cnt;

    logic [31:0]       pend;
    logic              load_hz;
    logic              flag_hz;
    logic              stall;
    logic              fire;
    logic              accept;

    op_ctrl_decode #(.DATA_W(DATA_W)) u_dec (
        .opid    (in_opid),
        .instr   (in_instr),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .rn      (dec_rn),
        .rm      (dec_rm),
        .rd      (dec_rd),
        .imm     (dec_imm),
        .src_use (dec_use)
    );

    // Registers whose load result is not yet readable.
    always_comb begin
        pend = '0;
        if (out_valid && ctrl_reg.read_en) begin
            pend[out_rd] = 1'b1;
        end
        for (int i = 0; i < LOAD_LAT; i++) begin
            if (shadow_valid[i]) begin
                pend[shadow_rd[i]] = 1'b1;
            end
        end
        pend[ZERO_REG] = 1'b0;
    end

    assign load_hz = (dec_use.rn & pend[dec_rn]) |
                     (dec_use.rm & pend[dec_rm]) |
                     (dec_use.rd & pend[dec_rd]);
    assign flag_hz = (dec_ctrl.br_type == BR_BLT) &
                     ((out_valid & ctrl_reg.flag_en) | (flag_cnt != '0));
    assign stall    = in_valid & (load_hz | flag_hz);
    assign in_ready = ~flush & ~stall & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;
    // A bundle squashed by flush never reaches execute, so it is not a fire.
    assign fire     = out_valid & out_ready & ~flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_rn      <= '0;
            out_rm      <= '0;
            out_rd      <= '0;
            out_imm     <= '0;
            out_illegal <= 1'b0;
            ctrl_reg    <= CTRL_NONE;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_rn      <= dec_rn;
            out_rm      <= dec_rm;
            out_rd      <= dec_rd;
            out_imm     <= dec_imm;
            out_illegal <= dec_illegal;
            ctrl_reg    <= dec_ctrl;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < LOAD_LAT; i++) begin
                shadow_valid[i] <= 1'b0;
                shadow_rd[i]    <= '0;
            end
        end else begin
            shadow_valid[0] <= fire & ctrl_reg.read_en;
            shadow_rd[0]    <= out_rd;
            for (int i = 1; i < LOAD_LAT; i++) begin
                shadow_valid[i] <= shadow_valid[i-1];
                shadow_rd[i]    <= shadow_rd[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_cnt <= '0;
        end else if (fire && ctrl_reg.flag_en) begin
            flag_cnt <= CNT_W'(FLAG_LAT);
        end else if (flag_cnt != '0) begin
            flag_cnt <= flag_cnt - CNT_W'(1);
        end
    end

    assign out_reg2loc  = ctrl_reg.reg2loc;
    assign out_alusrc   = ctrl_reg.alusrc;
    assign out_regwrite = ctrl_reg.regwrite;
    assign out_memwrite = ctrl_reg.memwrite;
    assign out_uncondbr = ctrl_reg.uncondbr;
    assign out_constsel = ctrl_reg.constsel;
    assign out_flag_en  = ctrl_reg.flag_en;
    assign out_reg3loc  = ctrl_reg.reg3loc;
    assign out_read_en  = ctrl_reg.read_en;
    assign out_memtoreg = ctrl_reg.memtoreg;
    assign out_alu_op   = ctrl_reg.alu_op;
    assign out_br_type  = ctrl_reg.br_type;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed instruction sequences with literal
// expectations, plus a cycle-by-cycle comparison against a behavioural model
// that tracks hazards as "readable from cycle N" timestamps.
module tb_decode_stage;

    localparam int DATA_W   = 64;
    localparam int LOAD_LAT = 1;
    localparam int FLAG_LAT = 1;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        in_opid = '0;
    logic [31:0]       in_instr = '0;
    logic [DATA_W-1:0] in_pc = '0;
    logic              flush = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [DATA_W-1:0] out_pc;
    logic [4:0]        out_rn, out_rm, out_rd;
    logic [DATA_W-1:0] out_imm;
    logic              out_reg2loc, out_alusrc, out_regwrite, out_memwrite;
    logic              out_uncondbr, out_constsel, out_flag_en, out_reg3loc, out_read_en;
    logic [1:0]        out_memtoreg;
    logic [2:0]        out_alu_op;
    logic [2:0]        out_br_type;
    logic              out_illegal;

    always #5 clk = ~clk;

    decode_stage #(.DATA_W(DATA_W), .LOAD_LAT(LOAD_LAT), .FLAG_LAT(FLAG_LAT)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opid(in_opid), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_rn(out_rn), .out_rm(out_rm), .out_rd(out_rd),
        .out_imm(out_imm),
        .out_reg2loc(out_reg2loc), .out_alusrc(out_alusrc), .out_regwrite(out_regwrite),
        .out_memwrite(out_memwrite), .out_uncondbr(out_uncondbr), .out_constsel(out_constsel),
        .out_flag_en(out_flag_en), .out_reg3loc(out_reg3loc), .out_read_en(out_read_en),
        .out_memtoreg(out_memtoreg), .out_alu_op(out_alu_op), .out_br_type(out_br_type),
        .out_illegal(out_illegal)
    );

    logic [17:0] dut_ctrl;
    assign dut_ctrl = {out_reg2loc, out_alusrc, out_regwrite, out_memwrite, out_uncondbr,
                       out_constsel, out_flag_en, out_reg3loc, out_read_en,
                       out_memtoreg, out_alu_op, out_br_type, out_illegal};

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [4:0]  rn, rm, rd;
        logic [63:0] imm;
        logic [17:0] ctrl;
        bit          use_rn, use_rm, use_rd;
        bit          read_en, flag_en;
    } exp_t;

    function automatic longint sext(input longint v, input int bits);
        longint half = longint'(1) << (bits - 1);
        return (v >= half) ? v - (half << 1) : v;
    endfunction

    function automatic exp_t model_decode(input logic [3:0] op, input logic [31:0] ins);
        exp_t e;
        bit r2l = 0, asrc = 0, rw = 0, mw = 0, ub = 0, cs = 0, fe = 0, r3 = 0, re = 0, ill = 0;
        bit f_rn = 0, f_rm = 0, f_rd = 0, link = 0;
        logic [1:0] mtr = 2'b00;
        logic [2:0] alu = 3'b000;
        logic [2:0] br  = 3'd0;
        longint imm = 0;
        e.use_rn = 0; e.use_rm = 0; e.use_rd = 0;
        case (op)
            4'd0: begin asrc = 1; cs = 1; rw = 1; alu = 3'b010; f_rn = 1; f_rd = 1;
                        imm = longint'(ins[21:10]); e.use_rn = 1; end
            4'd1, 4'd9: begin rw = 1; fe = 1; alu = (op == 4'd9) ? 3'b011 : 3'b010;
                        f_rn = 1; f_rm = 1; f_rd = 1; e.use_rn = 1; e.use_rm = 1; end
            4'd2: begin br = 3'd4; imm = sext(longint'(ins[23:5]), 19); end
            4'd3: begin ub = 1; br = 3'd1; imm = sext(longint'(ins[25:0]), 26); end
            4'd4: begin ub = 1; rw = 1; mtr = 2'b10; r3 = 1; br = 3'd2; link = 1;
                        imm = sext(longint'(ins[25:0]), 26); end
            4'd5: begin ub = 1; br = 3'd3; f_rn = 1; e.use_rn = 1; end
            4'd6: begin r2l = 1; br = 3'd5; f_rd = 1; e.use_rd = 1;
                        imm = sext(longint'(ins[23:5]), 19); end
            4'd7: begin asrc = 1; rw = 1; mtr = 2'b01; re = 1; alu = 3'b010; f_rn = 1; f_rd = 1;
                        e.use_rn = 1; imm = sext(longint'(ins[20:12]), 9); end
            4'd8: begin r2l = 1; asrc = 1; mw = 1; alu = 3'b010; f_rn = 1; f_rd = 1;
                        e.use_rn = 1; e.use_rd = 1; imm = sext(longint'(ins[20:12]), 9); end
            default: ill = 1;
        endcase
        e.rn = f_rn ? ins[9:5] : 5'd0;
        e.rm = f_rm ? ins[20:16] : 5'd0;
        e.rd = link ? 5'd30 : (f_rd ? ins[4:0] : 5'd0);
        e.imm = imm;
        e.read_en = re;
        e.flag_en = fe;
        e.ctrl = {r2l, asrc, rw, mw, ub, cs, fe, r3, re, mtr, alu, br, ill};
        return e;
    endfunction

    bit          m_valid;
    exp_t        m;
    logic [63:0] m_pc;
    int          cyc;
    int          load_until [32];
    int          flag_until;

    function automatic bit pending(input logic [4:0] r);
        if (r == 5'd31) return 0;
        if (m_valid && m.read_en && m.rd == r) return 1;
        return cyc <= load_until[r];
    endfunction

    function automatic bit model_ready();
        exp_t d = model_decode(in_opid, in_instr);
        bit hz = 0;
        if (d.use_rn && pending(d.rn)) hz = 1;
        if (d.use_rm && pending(d.rm)) hz = 1;
        if (d.use_rd && pending(d.rd)) hz = 1;
        if (in_opid == 4'd2 && ((m_valid && m.flag_en) || cyc <= flag_until)) hz = 1;
        return !flush && !(in_valid && hz) && (!m_valid || out_ready);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid <= 0;
            m <= '{default: 0};
            m_pc <= '0;
            cyc <= 0;
            flag_until <= -100;
            for (int r = 0; r < 32; r++) load_until[r] <= -100;
        end else begin
            if (m_valid && out_ready && !flush) begin
                if (m.read_en) load_until[m.rd] <= cyc + LOAD_LAT;
                if (m.flag_en) flag_until <= cyc + FLAG_LAT;
            end
            if (flush) m_valid <= 0;
            else if (in_valid && model_ready()) begin
                m_valid <= 1;
                m <= model_decode(in_opid, in_instr);
                m_pc <= in_pc;
            end else if (out_ready) m_valid <= 0;
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        chk("out_valid", out_valid, m_valid);
        if (in_valid) chk("in_ready", in_ready, model_ready());
        chk("out_pc", out_pc, m_pc);
        chk("out_rn", out_rn, m.rn);
        chk("out_rm", out_rm, m.rm);
        chk("out_rd", out_rd, m.rd);
        chk("out_imm", out_imm, m.imm);
        chk("ctrl", dut_ctrl, m.ctrl);
    end

    // ---------------- directed stimulus ----------------
    task automatic drive(input logic [3:0] op, input logic [31:0] ins, input logic [63:0] pc);
        in_valid = 1'b1;
        in_opid  = op;
        in_instr = ins;
        in_pc    = pc;
    endtask

    // Returns #1 after the accepting edge with in_valid dropped.
    task automatic wait_accept(output int stalls);
        bit done = 0;
        stalls = 0;
        for (int k = 0; k < 30 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                done = 1;
            end else begin
                stalls++;
            end
        end
        chk("accept_in_budget", done, 1);
    endtask

    typedef struct { logic [3:0] op; logic [31:0] ins; } vec_t;
    vec_t indep [5];
    int   s;

    initial begin
        indep[0] = '{4'd8, 32'h0000_3107};   // STUR X7,[X8,#3]
        indep[1] = '{4'd6, 32'h0000_0109};   // CBZ X9,#8
        indep[2] = '{4'd5, 32'h0000_0140};   // BR X10
        indep[3] = '{4'd3, 32'h03FF_FFFF};   // B #-1
        indep[4] = '{4'd0, 32'h0000_1441};   // ADDI X1,X2,#5

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_illegal", out_illegal, 0);
        chk("rst_out_imm", out_imm, 0);
        reset_n = 1'b1;

        // ADDI X1,X2,#5
        drive(4'd0, 32'h0000_1441, 64'h100);
        wait_accept(s);
        chk("addi_valid", out_valid, 1);
        chk("addi_rn", out_rn, 2);
        chk("addi_rd", out_rd, 1);
        chk("addi_imm", out_imm, 5);
        chk("addi_alu_op", out_alu_op, 3'b010);
        chk("addi_ctl", {out_alusrc, out_constsel, out_regwrite, out_flag_en}, 4'b1110);

        // LDUR X3,[X4,#-8] then dependant ADDS X5,X3,X6
        drive(4'd7, 32'h001F_8083, 64'h104);
        wait_accept(s);
        chk("ldur_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        chk("ldur_memtoreg", out_memtoreg, 2'b01);
        chk("ldur_read_en", out_read_en, 1);
        drive(4'd1, 32'h0006_0065, 64'h108);
        wait_accept(s);
        chk("load_use_stalls", s, 2);

        // SUBS X0,X1,X2 then B.LT #-4
        drive(4'd9, 32'h0002_0020, 64'h10C);
        wait_accept(s);
        drive(4'd2, 32'h00FF_FF8B, 64'h110);
        wait_accept(s);
        chk("flag_stalls", s, 2);
        chk("blt_br_type", out_br_type, 3'd4);
        chk("blt_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);

        // Independent ops back to back
        for (int i = 0; i < 5; i++) begin
            drive(indep[i].op, indep[i].ins, 64'h200 + 64'(i * 4));
            wait_accept(s);
            chk("indep_stalls", s, 0);
        end

        // X31 never forms a hazard
        drive(4'd7, 32'h0000_005F, 64'h300);
        wait_accept(s);
        drive(4'd1, 32'h001F_03E1, 64'h304);
        wait_accept(s);
        chk("x31_stalls", s, 0);

        // BL held under backpressure
        drive(4'd4, 32'h0000_0010, 64'h400);
        wait_accept(s);
        out_ready = 1'b0;
        drive(4'd0, 32'h0000_1441, 64'h404);
        #1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            chk("bl_hold_valid", out_valid, 1);
            chk("bl_hold_rd", out_rd, 30);
            chk("bl_hold_memtoreg", out_memtoreg, 2'b10);
            chk("bl_hold_reg3loc", out_reg3loc, 1);
            chk("bl_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        wait_accept(s);
        chk("after_hold_stalls", s, 0);

        // Flush with a valid bundle and a waiting instruction
        out_ready = 1'b0;
        drive(4'd9, 32'h0002_0020, 64'h500);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", out_valid, 0);
        out_ready = 1'b1;

        // Flushed LDUR is dropped, so its dependant sees no hazard
        drive(4'd7, 32'h001F_8083, 64'h600);
        wait_accept(s);
        drive(4'd1, 32'h0006_0065, 64'h604);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wait_accept(s);
        chk("flushed_load_stalls", s, 0);

        // Illegal opid, then B.LT sees no flag hazard from it
        drive(4'd0, 32'h0000_1441, 64'h700);
        wait_accept(s);
        drive(4'd15, 32'h1234_5678, 64'h704);
        wait_accept(s);
        chk("illegal_valid", out_valid, 1);
        chk("illegal_ctrl", dut_ctrl, 18'h1);
        drive(4'd2, 32'h00FF_FF8B, 64'h708);
        wait_accept(s);
        chk("illegal_no_stall", s, 0);

        // Reset mid-stall
        drive(4'd7, 32'h001F_8083, 64'h800);
        wait_accept(s);
        drive(4'd1, 32'h0006_0065, 64'h804);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_rd", out_rd, 0);
        chk("midrst_read_en", out_read_en, 0);
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        wait_accept(s);
        chk("post_reset_stalls", s, 0);
        chk("post_reset_rn", out_rn, 3);

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
